pb_debouncer: RTL and testbench
===============================

// Module: pb_debouncer
//
// PURPOSE
// Conditions a raw asynchronous pushbutton/switch input into a clean, glitch-free level.
// It sits directly upstream of the level counter and drives its lv_in input.
// - Synchronises the pin into the CLK100MHZ domain.
// - Rejects bounce shorter than a programmable qualification time.
// - Also emits single-cycle press/release strobes for edge-triggered consumers.
//
// PARAMETERS
// DEBOUNCE_CYCLES  1_000_000  stable-input qualification time in clock cycles (10 ms @ 100 MHz); legal >= 2
// SYNC_STAGES      2          flip-flops in the input synchroniser; legal >= 2
//
// PORTS
// CLK100MHZ    in   1  system clock, 100 MHz
// reset        in   1  asynchronous, active-high reset
// PB_in        in   1  raw pin; asynchronous, may bounce
// PB_level     out  1  debounced level (feeds lv_in downstream)
// PB_pressed   out  1  one-cycle strobe on the qualified 0->1 transition of PB_level
// PB_released  out  1  one-cycle strobe on the qualified 1->0 transition of PB_level
//
// BEHAVIOUR
// - Reset (async assert, sync-to-clock release is the system's job):
//   - synchroniser flops = 0, state = IDLE_LOW, counter = 0.
//   - PB_level = 0, PB_pressed = 0, PB_released = 0.
// - Synchroniser: PB_in passes through SYNC_STAGES flops; only the last stage (sync) is used.
// - Counter: width $clog2(DEBOUNCE_CYCLES), unsigned.
//   - Cleared on every entry to a WAIT state.
//   - Never wraps: it exits its WAIT state at DEBOUNCE_CYCLES-1.
// - FSM (4 states), evaluated every rising edge:
//   - IDLE_LOW:
//     - sync=1 -> WAIT_HIGH, cnt<=0.
//     - else stay.
//   - WAIT_HIGH:
//     - sync=0 -> IDLE_LOW (bounce rejected, no strobe).
//     - cnt==DEBOUNCE_CYCLES-1 -> IDLE_HIGH, PB_level<=1, PB_pressed<=1.
//     - else cnt<=cnt+1.
//   - IDLE_HIGH:
//     - sync=0 -> WAIT_LOW, cnt<=0.
//     - else stay.
//   - WAIT_LOW:
//     - sync=1 -> IDLE_HIGH (bounce rejected, no strobe).
//     - cnt==DEBOUNCE_CYCLES-1 -> IDLE_LOW, PB_level<=0, PB_released<=1.
//     - else cnt<=cnt+1.
// - All outputs are registered.
//   - PB_pressed/PB_released are high for exactly one cycle, coincident with the PB_level edge.
//   - The two strobes are never high together.
// - Latency: count the first edge that samples PB_in at its new value as edge 1.
//   - PB_level changes after edge SYNC_STAGES+DEBOUNCE_CYCLES+1, provided PB_in holds the new value.
//   - Any opposite sample seen at sync before then restarts qualification; PB_level stays unchanged.
// - PB_level holds its value throughout the WAIT states; no intermediate glitches reach the output.
// - Reset mid-operation: any WAIT progress is discarded and outputs go low immediately.
//   - If PB_in is still high after reset release, it qualifies as a fresh press, with a PB_pressed strobe.
// - Pulse widths below DEBOUNCE_CYCLES+1 cycles at sync never change PB_level.
//
// TESTING  (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
// 1. Reset asserted with PB_in=1 -> all outputs 0 during reset.
//    Release reset -> PB_level=1 and PB_pressed=1 for 1 cycle, 7 edges after release.
// 2. Clean press: PB_in 0->1 held -> PB_level rises after edge 7 with a 1-cycle PB_pressed.
//    Release held -> PB_level falls after edge 7 with a 1-cycle PB_released.
// 3. Bounce: PB_in toggles 1,0,1,0 every 2 cycles, then holds 1 -> no strobes during the toggling.
//    PB_level rises 7 edges after the final 0->1 sample.
// 4. Glitch rejection: PB_level=1, then PB_in low for 3 cycles and back high -> PB_level stays 1, no PB_released.
// 5. Async reset asserted mid-WAIT_HIGH (counter=2), between clock edges -> PB_level/strobes read 0 immediately.
//    After release, with PB_in high, the full 7-edge qualification restarts.
// 6. Long hold: PB_in high for 1000 cycles -> exactly one PB_pressed, PB_level constant 1, counter does not wrap.

Source files
------------

// File: rtl/pb_debouncer.sv
// Pushbutton debouncer: synchronises a raw, bouncing pin into the clock domain,
// qualifies each level change over DEBOUNCE_CYCLES stable samples, and emits
// a clean level plus single-cycle press/release strobes aligned with its edges.
module pb_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,  // qualification time in clocks, >= 2
  parameter int SYNC_STAGES     = 2           // synchroniser depth, >= 2
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic PB_in,
  output logic PB_level,
  output logic PB_pressed,
  output logic PB_released
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  state_e        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          level_q,    level_d;
  logic          pressed_q,  pressed_d;
  logic          released_q, released_d;

  // Shift the raw pin through the synchroniser chain; only the last stage is trusted.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      // NOTE: clocked state always uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, which is what makes the chain shift.
      sync_q <= {sync_q[SYNC_STAGES-2:0], PB_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Next-state logic: track the candidate level and count how long it has been stable.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred. Strobes default low.
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end

      WAIT_HIGH: begin
        if (!sync) begin
          state_d = IDLE_LOW;               // bounce: drop back without a strobe
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE_HIGH;
          level_d   = 1'b1;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      IDLE_HIGH: begin
        if (!sync) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end

      WAIT_LOW: begin
        if (sync) begin
          state_d = IDLE_HIGH;              // bounce: drop back without a strobe
        end else if (cnt_q == CNT_MAX) begin
          state_d    = IDLE_LOW;
          level_d    = 1'b0;
          released_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE_LOW;
        level_d = 1'b0;
      end
    endcase
  end

  // Register FSM state, counter and all outputs so nothing combinational reaches the pins.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      // NOTE: reset clears every flop here, including the counter, so any
      // qualification in progress is discarded and outputs drop low at once.
      state_q    <= IDLE_LOW;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign PB_level    = level_q;
  assign PB_pressed  = pressed_q;
  assign PB_released = released_q;

endmodule

// File: tb/tb_pb_debouncer.sv
// Testbench for pb_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Stimulus pushes each expected output event (kind + edge number) into a
// queue; an independent monitor pops and compares whenever the DUT output
// level changes or a strobe fires.
module tb_pb_debouncer;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + DEB + 1;   // edges from first new sample to level change

  typedef enum int {EV_NONE = 0, EV_PRESS = 1, EV_RELEASE = 2, EV_BAD = 3} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
  } exp_t;

  logic CLK100MHZ = 1'b0;
  logic reset     = 1'b1;
  logic PB_in     = 1'b0;
  logic PB_level, PB_pressed, PB_released;

  exp_t exp_q[$];
  int   edge_cnt    = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  logic prev_level  = 1'b0;
  ev_e  obs_kind;
  exp_t head;

  pb_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .reset      (reset),
    .PB_in      (PB_in),
    .PB_level   (PB_level),
    .PB_pressed (PB_pressed),
    .PB_released(PB_released)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Rising-edge counter used to time-stamp expected and observed events.
  always @(posedge CLK100MHZ) edge_cnt = edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, edge %0d)", name, act, exp, $time, edge_cnt);
    end
  endtask

  task automatic check_outputs(input string name, input logic lvl, input logic pr, input logic rl);
    check({name, ".level"},    {31'd0, PB_level},    {31'd0, lvl});
    check({name, ".pressed"},  {31'd0, PB_pressed},  {31'd0, pr});
    check({name, ".released"}, {31'd0, PB_released}, {31'd0, rl});
  endtask

  // Drive PB_in on a falling edge, optionally queue the event it must cause,
  // and hold the value for 'hold' rising edges.
  task automatic drive(input logic v, input int hold, input ev_e ev);
    @(negedge CLK100MHZ);
    PB_in = v;
    if (ev != EV_NONE) exp_q.push_back('{kind: ev, cyc: edge_cnt + LAT});
    repeat (hold - 1) @(negedge CLK100MHZ);
  endtask

  // Monitor: classify every output activity and compare against the queue head.
  always @(negedge CLK100MHZ) begin
    if (reset) begin
      prev_level = 1'b0;
    end else begin
      if (PB_level !== prev_level || PB_pressed !== 1'b0 || PB_released !== 1'b0) begin
        if (PB_level === 1'b1 && prev_level === 1'b0 && PB_pressed === 1'b1 && PB_released === 1'b0)
          obs_kind = EV_PRESS;
        else if (PB_level === 1'b0 && prev_level === 1'b1 && PB_released === 1'b1 && PB_pressed === 1'b0)
          obs_kind = EV_RELEASE;
        else
          obs_kind = EV_BAD;
        if (exp_q.size() == 0) begin
          check("unexpected_event", obs_kind, EV_NONE);
        end else begin
          head = exp_q.pop_front();
          check("event_kind", obs_kind, head.kind);
          check("event_edge", edge_cnt, head.cyc);
        end
      end
      prev_level = PB_level;
    end
  end

  initial begin
    // 1: reset held with the button pressed; outputs stay low, then a fresh press qualifies.
    PB_in = 1'b1;
    repeat (3) begin
      @(negedge CLK100MHZ);
      check_outputs("in_reset", 1'b0, 1'b0, 1'b0);
    end
    @(negedge CLK100MHZ);
    reset = 1'b0;
    exp_q.push_back('{kind: EV_PRESS, cyc: edge_cnt + LAT});
    repeat (12) @(negedge CLK100MHZ);
    check_outputs("after_reset_press", 1'b1, 1'b0, 1'b0);

    // 2: clean release, press, release.
    drive(1'b0, 12, EV_RELEASE);
    check_outputs("clean_release", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 12, EV_PRESS);
    check_outputs("clean_press", 1'b1, 1'b0, 1'b0);
    drive(1'b0, 12, EV_RELEASE);

    // 3: bounce every 2 cycles, then settle high.
    drive(1'b1, 2, EV_NONE);
    drive(1'b0, 2, EV_NONE);
    drive(1'b1, 2, EV_NONE);
    drive(1'b0, 2, EV_NONE);
    drive(1'b1, 12, EV_PRESS);
    check_outputs("bounce_settled", 1'b1, 1'b0, 1'b0);

    // 4: low glitches of 3 and 4 cycles are rejected; 5 cycles is the shortest that qualifies.
    drive(1'b0, 3, EV_NONE);
    drive(1'b1, 10, EV_NONE);
    check_outputs("glitch3", 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4, EV_NONE);
    drive(1'b1, 10, EV_NONE);
    check_outputs("glitch4", 1'b1, 1'b0, 1'b0);
    drive(1'b0, 5, EV_RELEASE);
    drive(1'b1, 12, EV_PRESS);

    // Reset inside WAIT_LOW with the level high: output must drop immediately.
    @(negedge CLK100MHZ);
    PB_in = 1'b0;
    repeat (4) @(posedge CLK100MHZ);
    #2;
    check_outputs("pre_reset_wait_low", 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_outputs("reset_wait_low", 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK100MHZ);
    reset = 1'b0;
    repeat (12) @(negedge CLK100MHZ);
    check_outputs("after_reset_low", 1'b0, 1'b0, 1'b0);

    // 5: reset in WAIT_HIGH with counter at 2, then full requalification.
    @(negedge CLK100MHZ);
    PB_in = 1'b1;
    repeat (5) @(posedge CLK100MHZ);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("reset_wait_high", 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK100MHZ);
    reset = 1'b0;
    exp_q.push_back('{kind: EV_PRESS, cyc: edge_cnt + LAT});
    repeat (12) @(negedge CLK100MHZ);
    check_outputs("requalified", 1'b1, 1'b0, 1'b0);

    // 6: long hold produces exactly one press and no counter wrap.
    drive(1'b0, 12, EV_RELEASE);
    drive(1'b1, 1000, EV_PRESS);
    check_outputs("long_hold", 1'b1, 1'b0, 1'b0);
    drive(1'b0, 12, EV_RELEASE);

    repeat (5) @(negedge CLK100MHZ);
    check("pending_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
